load_store_unit: RTL and testbench

Load/store unit between the EX/MEM pipeline register and the word-addressed data memory. Accepts one load or store per request (byte, halfword, word), drives the memory's read/write strobes, address and write data, and returns extended load data to MEM/WB. Sub-word stores use a read-modify-write sequence because the memory only writes whole words. The block stalls the pipeline while an access is in flight.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (see load_store_unit.sv).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int unsigned LSU_CNT_W = 4;

  // Halfword needs addr[0]=0; word (and size 11) needs addr[1:0]=0.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge.
// Word size (10 or 11) ignores the lane; halfword uses lane[1] only.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] shifted;

  // Shift the selected lane down and extend; overlay store data onto the word.
  always_comb begin
    shifted = '0;
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        shifted = word_i >> {lane_i, 3'b000};
        load_o  = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        merge_o = word_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        shifted = word_i >> {lane_i[1], 4'b0000};
        load_o  = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        merge_o = word_i;
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a word-addressed data memory.
// Sub-word stores are read-modify-write. Define LSU_MISALIGN_CHECK_EN to
// complete misaligned half/word accesses as errors without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [LSU_CNT_W-1:0] CNT_INIT = LSU_CNT_W'(MEM_LAT - 1);

  lsu_state_e           state_q, state_d;
  logic [LSU_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic                 we_q, we_d;
  logic                 uns_q, uns_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          word_q, word_d;
  logic                 err_q, err_d;

  logic        accept;
  logic        req_mis;
  logic        req_word;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign accept   = req_valid_i && req_ready_o;
  assign req_word = (req_size_i != SZ_BYTE) && (req_size_i != SZ_HALF);

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_mis = lsu_misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  lsu_lane_align u_align (
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .word_i     (word_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // State and request/data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in IDLE/RESP, count read latency, capture read word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          err_d   = req_mis;
          cnt_d   = CNT_INIT;
          if (req_mis)                    state_d = ST_RESP;
          else if (req_we_i && req_word)  state_d = ST_WRITE;
          else                            state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          word_d  = mem_rdata_i;
          state_d = we_q ? ST_WRITE : ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and latched request.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) || (state_q == ST_RESP);
    stall_o     = (req_valid_i && req_ready_o) || (state_q == ST_READ) || (state_q == ST_WRITE);
    mem_read_o  = (state_q == ST_READ);
    mem_write_o = (state_q == ST_WRITE);
    mem_addr_o  = {addr_q[31:2], 2'b00};
    mem_wdata_o = (state_q == ST_WRITE) ? merge_data : '0;
    rsp_valid_o = (state_q == ST_RESP);
    rsp_rdata_o = (state_q == ST_RESP && !we_q && !err_q) ? load_data : '0;
`ifdef LSU_MISALIGN_CHECK_EN
    rsp_err_o   = (state_q == ST_RESP) && err_q;
`else
    rsp_err_o   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven vectors with a
// response scoreboard on a MEM_LAT=1 instance, plus hand-written timing
// sequences (store/load latency, RMW, misalign, MEM_LAT=3 back-to-back, reset).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mem_clr;

  // Instance 1: MEM_LAT=1
  logic        v1, we1, uns1;
  logic [1:0]  sz1;
  logic [31:0] addr1, wd1;
  logic        rdy1, rv1, err1, stall1, mr1, mw1;
  logic [31:0] rd1, ma1, mwd1, mrd1;

  // Instance 3: MEM_LAT=3
  logic        v3, we3, uns3;
  logic [1:0]  sz3;
  logic [31:0] addr3, wd3;
  logic        rdy3, rv3, err3, stall3, mr3, mw3;
  logic [31:0] rd3, ma3, mwd3, mrd3;

  load_store_unit #(.MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1), .req_size_i(sz1),
    .req_unsigned_i(uns1), .req_addr_i(addr1), .req_wdata_i(wd1),
    .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(err1), .stall_o(stall1),
    .mem_read_o(mr1), .mem_write_o(mw1), .mem_addr_o(ma1), .mem_wdata_o(mwd1),
    .mem_rdata_i(mrd1)
  );

  load_store_unit #(.MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_we_i(we3), .req_size_i(sz3),
    .req_unsigned_i(uns3), .req_addr_i(addr3), .req_wdata_i(wd3),
    .rsp_valid_o(rv3), .rsp_rdata_o(rd3), .rsp_err_o(err3), .stall_o(stall3),
    .mem_read_o(mr3), .mem_write_o(mw3), .mem_addr_o(ma3), .mem_wdata_o(mwd3),
    .mem_rdata_i(mrd3)
  );

  // Memory model for instance 1 (64 words); instance 3 reads an address pattern.
  logic [31:0] mem1 [64];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem1[i] <= '0;
    end else if (mw1) begin
      mem1[ma1[7:2]] <= mwd1;
    end
  end
  assign mrd1 = mem1[ma1[7:2]];
  assign mrd3 = ma3 ^ 32'h5A5A_0000;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] er;
    logic        ee;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.er = er; v.ee = ee;
    return v;
  endfunction

  // Scoreboard monitor and strobe sanity for instance 1.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (mr1 || mw1) begin
        chk("strobe_excl", {31'b0, mr1 & mw1}, 32'h0);
        chk("mem_addr_lsb", {30'b0, ma1[1:0]}, 32'h0);
      end
      if (rv1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h expected no response", rd1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rsp%0d_rdata", e.id), rd1, e.rdata);
          chk($sformatf("rsp%0d_err", e.id), {31'b0, err1}, {31'b0, e.err});
        end
      end
    end
  end

  // Present a request on instance 1; returns #1 after the accepting edge (cycle N+1).
  task automatic issue1(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit push, input logic [31:0] er, input logic ee, input int id);
    int t;
    @(negedge clk);
    v1 = 1'b1; we1 = we; sz1 = sz; uns1 = uns; addr1 = a; wd1 = wd;
    t = 0;
    while (!rdy1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy1) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue%0d_ready: got ready=0 for 50 cycles expected ready=1", id);
    end
    if (push) exp_q.push_back('{id: id, rdata: er, err: ee});
    @(posedge clk);
    #1;
    v1 = 1'b0;
  endtask

  task automatic drain(input int id);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain%0d: got %0d pending responses expected 0", id, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    v1 = 0; we1 = 0; sz1 = 0; uns1 = 0; addr1 = 0; wd1 = 0;
    v3 = 0; we3 = 0; sz3 = 0; uns3 = 0; addr3 = 0; wd3 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rv1}, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_err", {31'b0, err1}, 0);
    chk("rst_stall", {31'b0, stall1}, 0);
    chk("rst_read", {31'b0, mr1}, 0);
    chk("rst_write", {31'b0, mw1}, 0);
    chk("rst_mem_addr", ma1, 0);
    chk("rst_mem_wdata", mwd1, 0);
    chk("rst_ready_idle", {31'b0, rdy1}, 1);
    rst = 1'b0; mem_clr = 1'b0;

    // Word store timing, then word load timing.
    issue1(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 100);
    chk("sw_write_n1", {31'b0, mw1}, 1);
    chk("sw_wdata_n1", mwd1, 32'hDEADBEEF);
    chk("sw_addr_n1", ma1, 32'h10);
    chk("sw_rsp_n1", {31'b0, rv1}, 0);
    @(posedge clk); #1;
    chk("sw_rsp_n2", {31'b0, rv1}, 1);
    chk("sw_stall_n2", {31'b0, stall1}, 0);
    drain(100);
    issue1(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, 101);
    chk("lw_read_n1", {31'b0, mr1}, 1);
    @(posedge clk); #1;
    chk("lw_rsp_n2", {31'b0, rv1}, 1);
    drain(101);

    // Byte read-modify-write.
    issue1(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 1, 32'h0, 1'b0, 102);
    drain(102);
    issue1(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000AA, 1, 32'h0, 1'b0, 103);
    chk("rmw_read_n1", {31'b0, mr1}, 1);
    chk("rmw_addr_n1", ma1, 32'h20);
    @(posedge clk); #1;
    chk("rmw_write_n2", {31'b0, mw1}, 1);
    chk("rmw_wdata_n2", mwd1, 32'h1122AA44);
    chk("rmw_rsp_n2", {31'b0, rv1}, 0);
    @(posedge clk); #1;
    chk("rmw_rsp_n3", {31'b0, rv1}, 1);
    drain(103);

    // Vector table; memory now: [0x10]=DEADBEEF, [0x20]=1122AA44.
    vt.push_back(mk(0, SZ_BYTE, 0, 32'h21, 0, 32'hFFFFFFAA, 0));
    vt.push_back(mk(0, SZ_BYTE, 1, 32'h21, 0, 32'h000000AA, 0));
    vt.push_back(mk(1, SZ_HALF, 0, 32'h22, 32'hFFFF8001, 32'h0, 0));
    vt.push_back(mk(0, SZ_HALF, 0, 32'h22, 0, 32'hFFFF8001, 0));
    vt.push_back(mk(0, SZ_HALF, 1, 32'h22, 0, 32'h00008001, 0));
    vt.push_back(mk(0, SZ_WORD, 0, 32'h20, 0, 32'h8001AA44, 0));
    vt.push_back(mk(1, SZ_BYTE, 0, 32'h23, 32'h0000007F, 32'h0, 0));
    vt.push_back(mk(0, SZ_BYTE, 0, 32'h23, 0, 32'h0000007F, 0));
    vt.push_back(mk(0, SZ_HALF, 0, 32'h20, 0, 32'hFFFFAA44, 0));
    vt.push_back(mk(0, SZ_BYTE, 1, 32'h20, 0, 32'h00000044, 0));
    vt.push_back(mk(1, 2'b11, 0, 32'h30, 32'hCAFEF00D, 32'h0, 0));
    vt.push_back(mk(0, 2'b11, 0, 32'h30, 0, 32'hCAFEF00D, 0));
    vt.push_back(mk(1, SZ_BYTE, 0, 32'h32, 32'h00005566, 32'h0, 0));
    vt.push_back(mk(0, SZ_WORD, 0, 32'h30, 0, 32'hCA66F00D, 0));
    vt.push_back(mk(0, SZ_HALF, 0, 32'h32, 0, 32'hFFFFCA66, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    vt.push_back(mk(1, SZ_HALF, 0, 32'h11, 32'h00001234, 32'h0, 1));
    vt.push_back(mk(0, SZ_WORD, 0, 32'h10, 0, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, SZ_HALF, 0, 32'h23, 0, 32'h0, 1));
`else
    vt.push_back(mk(1, SZ_HALF, 0, 32'h11, 32'h00001234, 32'h0, 0));
    vt.push_back(mk(0, SZ_WORD, 0, 32'h10, 0, 32'hDEAD1234, 0));
    vt.push_back(mk(0, SZ_HALF, 0, 32'h23, 0, 32'h00007F01, 0));
`endif
    for (int i = 0; i < vt.size(); i++) begin
      issue1(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata, 1, vt[i].er, vt[i].ee, i);
      drain(i);
    end

    // Misaligned word load timing.
`ifdef LSU_MISALIGN_CHECK_EN
    issue1(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, 104);
    chk("mis_rsp_n1", {31'b0, rv1}, 1);
    chk("mis_err_n1", {31'b0, err1}, 1);
    chk("mis_strobes_n1", {30'b0, mr1, mw1}, 0);
`else
    issue1(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 1, 32'hDEAD1234, 1'b0, 104);
    chk("mis_read_n1", {31'b0, mr1}, 1);
    chk("mis_addr_n1", ma1, 32'h10);
`endif
    drain(104);

    // MEM_LAT=3 back-to-back loads with valid held high.
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b0; sz3 = SZ_WORD; uns3 = 1'b0; addr3 = 32'h100; wd3 = '0;
    chk("b2b_ready0", {31'b0, rdy3}, 1);
    @(posedge clk); #1;
    addr3 = 32'h104;
    for (int k = 1; k <= 8; k++) begin
      logic er, ersp, est;
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k == 5) v3 = 1'b0;
      er   = (k >= 1 && k <= 3) || (k >= 5 && k <= 7);
      ersp = (k == 4) || (k == 8);
      est  = (k != 8);
      chk($sformatf("b2b_read_c%0d", k), {31'b0, mr3}, {31'b0, er});
      chk($sformatf("b2b_write_c%0d", k), {31'b0, mw3}, 0);
      chk($sformatf("b2b_rsp_c%0d", k), {31'b0, rv3}, {31'b0, ersp});
      chk($sformatf("b2b_stall_c%0d", k), {31'b0, stall3}, {31'b0, est});
      if (k == 4) chk("b2b_rdata_a", rd3, 32'h5A5A0100);
      if (k == 5) chk("b2b_addr_b", ma3, 32'h104);
      if (k == 8) chk("b2b_rdata_b", rd3, 32'h5A5A0104);
    end

    // Reset during the read phase of a byte store.
    issue1(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h55667788, 1, 32'h0, 1'b0, 105);
    drain(105);
    issue1(1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h00000099, 0, 32'h0, 1'b0, 106);
    chk("rstmid_read_n1", {31'b0, mr1}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_strobes", {30'b0, mr1, mw1}, 0);
    chk("rstmid_rsp", {31'b0, rv1}, 0);
    chk("rstmid_stall", {31'b0, stall1}, 0);
    chk("rstmid_addr", ma1, 0);
    chk("rstmid_wdata", mwd1, 0);
    chk("rstmid_rdata", rd1, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rstmid_nowrite_c%0d", k), {31'b0, mw1}, 0);
    end
    chk("rstmid_mem_word", mem1[16], 32'h55667788);
    issue1(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1, 32'h55667788, 1'b0, 107);
    drain(107);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
